// File: rtl/gpio_pkg.sv
// GPIO register-file shared definitions: register addresses, the widest
// supported pin count, the register-index enumeration and a byte-enable helper.
package gpio_pkg;

  localparam int GPIO_MAX_W = 32;

  localparam logic [2:0] GPIO_ADDR_DATA     = 3'd0;
  localparam logic [2:0] GPIO_ADDR_TRISTATE = 3'd1;
  localparam logic [2:0] GPIO_ADDR_IMASK    = 3'd2;
  localparam logic [2:0] GPIO_ADDR_PINSTATE = 3'd3;
  localparam logic [2:0] GPIO_ADDR_ISTAT    = 3'd4;
  localparam logic [2:0] GPIO_ADDR_IRISE    = 3'd5;
  localparam logic [2:0] GPIO_ADDR_IFALL    = 3'd6;
  localparam logic [2:0] GPIO_ADDR_TOGGLE   = 3'd7;

  typedef enum logic [2:0] {
    GPIO_REG_DATA     = GPIO_ADDR_DATA,
    GPIO_REG_TRISTATE = GPIO_ADDR_TRISTATE,
    GPIO_REG_IMASK    = GPIO_ADDR_IMASK,
    GPIO_REG_PINSTATE = GPIO_ADDR_PINSTATE,
    GPIO_REG_ISTAT    = GPIO_ADDR_ISTAT,
    GPIO_REG_IRISE    = GPIO_ADDR_IRISE,
    GPIO_REG_IFALL    = GPIO_ADDR_IFALL,
    GPIO_REG_TOGGLE   = GPIO_ADDR_TOGGLE
  } gpio_reg_e;

  // Expand the four byte enables into a 32-bit bit mask.
  function automatic logic [GPIO_MAX_W-1:0] gpio_byte_mask(input logic [3:0] wben);
    logic [GPIO_MAX_W-1:0] mask;
    mask = {GPIO_MAX_W{1'b0}};
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{wben[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pin input synchroniser chain plus a one-cycle delayed copy used to derive
// per-pin rise/fall strobes. All flops clear to 0 on reset, so a pin held
// high through reset shows up as a rise after release.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pin,
  output logic [W-1:0] sync_q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain_r [STAGES];
  logic [W-1:0] delayed_r;

  // Shift raw pin levels through the synchroniser chain and keep a delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_r[i] <= '0;
      end
      delayed_r <= '0;
    end else begin
      chain_r[0] <= pin;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
      delayed_r <= chain_r[STAGES-1];
    end
  end

  assign sync_q = chain_r[STAGES-1];
  assign rise   = sync_q & ~delayed_r;
  assign fall   = ~sync_q & delayed_r;

endmodule

// File: rtl/gpio_regfile.sv
// GPIO register file: data / tristate / interrupt-mask control, synchronised
// pin state, rise/fall edge interrupts with write-1-to-clear status and a
// registered interrupt request.
// Optional macro GPIO_TOGGLE_EN turns address 7 into a write-only TOGGLE
// register; without it address 7 is reserved and no toggle logic exists.
module gpio_regfile
  import gpio_pkg::*;
#(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:2]        addr,
  input  logic [3:0]        wben,
  input  logic              r_wn,
  input  logic [31:0]       wdata,
  input  logic [GPIO_W-1:0] ro_gpio_pinstate,
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] rf_gpio_datareg,
  output logic [GPIO_W-1:0] rf_gpio_tristate,
  output logic [GPIO_W-1:0] rf_gpio_interrupt_mask,
  output logic              irq
);

  gpio_reg_e reg_sel_s;

  logic [GPIO_MAX_W-1:0] wmask32_s;
  logic [GPIO_MAX_W-1:0] wbits32_s;
  logic [2*GPIO_MAX_W-1:0] wide_unused_s;
  logic [GPIO_W-1:0] wmask_s;
  logic [GPIO_W-1:0] wbits_s;

  logic [GPIO_W-1:0] sync_s, rise_s, fall_s, set_s, clr_s;

  logic [GPIO_W-1:0] data_r, tristate_r, imask_r, istat_r, irise_r, ifall_r;
  logic [GPIO_W-1:0] data_nxt_s, tristate_nxt_s, imask_nxt_s, istat_nxt_s;
  logic [GPIO_W-1:0] irise_nxt_s, ifall_nxt_s;
  logic [31:0]       rd_s;
  logic [31:0]       rdata_r;
  logic              irq_r;

  assign reg_sel_s = gpio_reg_e'(addr);

  // Byte-lane write data is formed at full bus width, then narrowed to the
  // implemented pins; bits at or above GPIO_W are simply dropped.
  assign wmask32_s     = gpio_byte_mask(wben);
  assign wbits32_s     = wdata & wmask32_s;
  assign wmask_s       = wmask32_s[GPIO_W-1:0];
  assign wbits_s       = wbits32_s[GPIO_W-1:0];
  assign wide_unused_s = {wmask32_s, wbits32_s};

  gpio_sync #(
    .W      (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (reset),
    .pin    (ro_gpio_pinstate),
    .sync_q (sync_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // Enabled edges set status; a W1C on the same bit loses to a new set.
  always_comb begin
    set_s = (rise_s & irise_r) | (fall_s & ifall_r);
    if (!r_wn && (reg_sel_s == GPIO_REG_ISTAT)) begin
      clr_s = wbits_s;
    end else begin
      clr_s = '0;
    end
    istat_nxt_s = (istat_r & ~clr_s) | set_s;
  end

  // Byte-masked next-state for the writable control registers.
  always_comb begin
    data_nxt_s     = data_r;
    tristate_nxt_s = tristate_r;
    imask_nxt_s    = imask_r;
    irise_nxt_s    = irise_r;
    ifall_nxt_s    = ifall_r;
    if (!r_wn) begin
      case (reg_sel_s)
        GPIO_REG_DATA:     data_nxt_s     = (data_r     & ~wmask_s) | wbits_s;
        GPIO_REG_TRISTATE: tristate_nxt_s = (tristate_r & ~wmask_s) | wbits_s;
        GPIO_REG_IMASK:    imask_nxt_s    = (imask_r    & ~wmask_s) | wbits_s;
        GPIO_REG_IRISE:    irise_nxt_s    = (irise_r    & ~wmask_s) | wbits_s;
        GPIO_REG_IFALL:    ifall_nxt_s    = (ifall_r    & ~wmask_s) | wbits_s;
`ifdef GPIO_TOGGLE_EN
        GPIO_REG_TOGGLE:   data_nxt_s     = data_r ^ wbits_s;
`endif
        default:           data_nxt_s     = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Read mux; PINSTATE returns synchronised levels, everything else not
  // listed (including TOGGLE and reserved) reads as zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (reg_sel_s)
      GPIO_REG_DATA:     rd_s[GPIO_W-1:0] = data_r;
      GPIO_REG_TRISTATE: rd_s[GPIO_W-1:0] = tristate_r;
      GPIO_REG_IMASK:    rd_s[GPIO_W-1:0] = imask_r;
      GPIO_REG_PINSTATE: rd_s[GPIO_W-1:0] = sync_s;
      GPIO_REG_ISTAT:    rd_s[GPIO_W-1:0] = istat_r;
      GPIO_REG_IRISE:    rd_s[GPIO_W-1:0] = irise_r;
      GPIO_REG_IFALL:    rd_s[GPIO_W-1:0] = ifall_r;
      default:           rd_s             = 32'h0000_0000;
    endcase
  end

  // Register state, read data (held while writing) and the interrupt request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r     <= '0;
      tristate_r <= '0;
      imask_r    <= '0;
      istat_r    <= '0;
      irise_r    <= '0;
      ifall_r    <= '0;
      rdata_r    <= 32'h0000_0000;
      irq_r      <= 1'b0;
    end else begin
      data_r     <= data_nxt_s;
      tristate_r <= tristate_nxt_s;
      imask_r    <= imask_nxt_s;
      istat_r    <= istat_nxt_s;
      irise_r    <= irise_nxt_s;
      ifall_r    <= ifall_nxt_s;
      if (r_wn) begin
        rdata_r <= rd_s;
      end else begin
        rdata_r <= rdata_r;
      end
      irq_r <= |(istat_r & imask_r);
    end
  end

  assign rdata                  = rdata_r;
  assign rf_gpio_datareg        = data_r;
  assign rf_gpio_tristate       = tristate_r;
  assign rf_gpio_interrupt_mask = imask_r;
  assign irq                    = irq_r;

endmodule

// File: tb/tb_gpio_regfile.sv
// Directed self-checking bench for gpio_regfile (GPIO_W=16, SYNC_STAGES=2).
// Honours GPIO_TOGGLE_EN in its expectations for address 7.
module tb_gpio_regfile;

  logic        clk;
  logic        reset;
  logic [4:2]  addr;
  logic [3:0]  wben;
  logic        r_wn;
  logic [31:0] wdata;
  logic [15:0] pins;
  logic [31:0] rdata;
  logic [15:0] datareg, tristate, imask;
  logic        irq;

  int tests_run;
  int tests_failed;

  gpio_regfile #(.GPIO_W(16), .SYNC_STAGES(2)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .addr                   (addr),
    .wben                   (wben),
    .r_wn                   (r_wn),
    .wdata                  (wdata),
    .ro_gpio_pinstate       (pins),
    .rdata                  (rdata),
    .rf_gpio_datareg        (datareg),
    .rf_gpio_tristate       (tristate),
    .rf_gpio_interrupt_mask (imask),
    .irq                    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    addr = a; wben = be; wdata = d; r_wn = 1'b0;
    @(posedge clk); #1;
    r_wn = 1'b1; wben = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; r_wn = 1'b1;
    @(posedge clk); #1;
    d = rdata;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      tests_run++;
      if (d !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, d, 32'h0);
      end
    end
    tests_run++;
    if ({irq, datareg, tristate, imask} !== 49'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs got irq=%b data=%h tri=%h mask=%h exp all 0", irq, datareg, tristate, imask);
    end
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    bus_write(3'd0, 4'b0010, 32'h1234_ABCD);
    bus_read(3'd0, d);
    tests_run++;
    if (d !== 32'h0000_AB00) begin
      tests_failed++;
      $display("FAIL data_byte1 got=%h exp=%h", d, 32'h0000_AB00);
    end
    bus_write(3'd0, 4'b1111, 32'hFFFF_1357);
    tests_run++;
    if (datareg !== 16'h1357) begin
      tests_failed++;
      $display("FAIL rf_datareg got=%h exp=%h", datareg, 16'h1357);
    end
    bus_read(3'd0, d);
    tests_run++;
    if (d !== 32'h0000_1357) begin
      tests_failed++;
      $display("FAIL data_upper_zero got=%h exp=%h", d, 32'h0000_1357);
    end
    bus_write(3'd1, 4'b0001, 32'hFFFF_FF5A);
    bus_read(3'd1, d);
    tests_run++;
    if (d !== 32'h0000_005A || tristate !== 16'h005A) begin
      tests_failed++;
      $display("FAIL tristate_byte0 got=%h/%h exp=%h", d, tristate, 32'h0000_005A);
    end
    bus_write(3'd0, 4'b0000, 32'hFFFF_FFFF);
    tests_run++;
    if (datareg !== 16'h1357) begin
      tests_failed++;
      $display("FAIL wben_zero got=%h exp=%h", datareg, 16'h1357);
    end
  endtask

  task automatic test_pinstate;
    logic [31:0] d;
    @(negedge clk);
    addr = 3'd3; r_wn = 1'b1; pins = 16'h00A4;
    cycles(2);
    tests_run++;
    if (rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL pinstate_early got=%h exp=%h", rdata, 32'h0);
    end
    cycles(1);
    tests_run++;
    if (rdata !== 32'h0000_00A4) begin
      tests_failed++;
      $display("FAIL pinstate_latency got=%h exp=%h", rdata, 32'h0000_00A4);
    end
    bus_write(3'd3, 4'b1111, 32'h0000_FFFF);
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'h0000_00A4) begin
      tests_failed++;
      $display("FAIL pinstate_ro got=%h exp=%h", d, 32'h0000_00A4);
    end
    @(negedge clk);
    pins = 16'h0000;
    cycles(4);
  endtask

  task automatic test_rise_irq;
    bus_write(3'd5, 4'b0011, 32'h0000_0001);
    bus_write(3'd2, 4'b0011, 32'h0000_0001);
    @(negedge clk);
    addr = 3'd4; r_wn = 1'b1; pins[0] = 1'b1;
    cycles(3);
    tests_run++;
    if (irq !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rise_edge3 got irq=%b istat=%h exp irq=0 istat=0", irq, rdata);
    end
    cycles(1);
    tests_run++;
    if (irq !== 1'b1 || rdata !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL rise_edge4 got irq=%b istat=%h exp irq=1 istat=1", irq, rdata);
    end
    bus_write(3'd4, 4'b1111, 32'h0000_0001);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1c_irq_lag got=%b exp=%b", irq, 1'b1);
    end
    cycles(1);
    tests_run++;
    if (irq !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL w1c_clear got irq=%b istat=%h exp irq=0 istat=0", irq, rdata);
    end
  endtask

  task automatic test_fall_mask;
    logic [31:0] d;
    bus_write(3'd2, 4'b0011, 32'h0000_0000);
    @(negedge clk); pins[15] = 1'b1;
    cycles(5);
    bus_write(3'd6, 4'b0011, 32'h0000_8000);
    @(negedge clk); pins[15] = 1'b0;
    cycles(5);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL fall_masked_irq got=%b exp=%b", irq, 1'b0);
    end
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'h0000_8000) begin
      tests_failed++;
      $display("FAIL fall_istat got=%h exp=%h", d, 32'h0000_8000);
    end
    bus_write(3'd2, 4'b0011, 32'h0000_8000);
    tests_run++;
    if (irq !== 1'b0 || imask !== 16'h8000) begin
      tests_failed++;
      $display("FAIL imask_lag got irq=%b mask=%h exp irq=0 mask=8000", irq, imask);
    end
    cycles(1);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL imask_unmask_irq got=%b exp=%b", irq, 1'b1);
    end
    bus_write(3'd4, 4'b1111, 32'hFFFF_FFFF);
    bus_write(3'd2, 4'b0011, 32'h0000_0000);
    cycles(2);
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    @(negedge clk); pins[0] = 1'b0;
    cycles(4);
    bus_write(3'd4, 4'b1111, 32'hFFFF_FFFF);
    @(negedge clk); pins[0] = 1'b1;
    cycles(2);
    bus_write(3'd4, 4'b1111, 32'h0000_0001);
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL set_beats_w1c got=%h exp=%h", d, 32'h0000_0001);
    end
    bus_write(3'd4, 4'b1111, 32'h0000_0001);
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL w1c_after got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_toggle;
    logic [31:0] d;
    logic [31:0] exp1, exp2;
`ifdef GPIO_TOGGLE_EN
    exp1 = 32'h0000_0FF0;
    exp2 = 32'h0000_0F0F;
`else
    exp1 = 32'h0000_00FF;
    exp2 = 32'h0000_00FF;
`endif
    bus_write(3'd0, 4'b1111, 32'h0000_00FF);
    bus_write(3'd7, 4'b1111, 32'h0000_0F0F);
    bus_read(3'd0, d);
    tests_run++;
    if (d !== exp1) begin
      tests_failed++;
      $display("FAIL toggle_data got=%h exp=%h", d, exp1);
    end
    bus_read(3'd7, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL toggle_read got=%h exp=%h", d, 32'h0);
    end
    bus_write(3'd7, 4'b0001, 32'hFFFF_FFFF);
    tests_run++;
    if ({16'h0000, datareg} !== exp2) begin
      tests_failed++;
      $display("FAIL toggle_byte_en got=%h exp=%h", datareg, exp2);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bus_write(3'd0, 4'b1111, 32'h0000_BEEF);
    bus_read(3'd0, d);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (datareg !== 16'h0 || rdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got data=%h rdata=%h irq=%b exp 0", datareg, rdata, irq);
    end
    @(negedge clk);
    reset = 1'b1;
    cycles(1);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    addr = 3'd0; wben = 4'h0; r_wn = 1'b1; wdata = 32'h0; pins = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_byte_write();
    test_pinstate();
    test_rise_irq();
    test_fall_mask();
    test_set_wins();
    test_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gpio_regfile.md
# gpio_regfile

Parametrised GPIO register file for the bus-attached GPIO peripheral; next generation of the 16-bit data/tristate/mask register block. It holds per-pin output data, tristate and interrupt-mask control. It adds the following:
- input synchronisation;
- rising/falling edge detection;
- a write-1-to-clear interrupt status register;
- a single registered interrupt request toward the system interrupt controller.

## Interface
- GPIO_W, 16, number of pins; legal 1..32
- SYNC_STAGES, 2, flops in each pin input synchroniser; legal 2..4
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  asynchronous, active-low reset
- addr  input  [4:2]  word address of the register accessed
- wben  input  4  byte write enables; wben[i] covers wdata[8i+7:8i]
- r_wn  input  1  1 = read, 0 = write
- wdata  input  32  write data
- ro_gpio_pinstate  input  GPIO_W  raw, asynchronous pin levels
- rdata  output  32  registered read data
- rf_gpio_datareg  output  GPIO_W  output data register
- rf_gpio_tristate  output  GPIO_W  1 = pin driven, 0 = high-Z
- rf_gpio_interrupt_mask  output  GPIO_W  1 = interrupt enabled for pin
- irq  output  1  registered OR of (ISTAT & IMASK)

## Operation
- Register map (addr):
  - 0 DATA (RW)
  - 1 TRISTATE (RW)
  - 2 IMASK (RW)
  - 3 PINSTATE (RO; synchronised pins)
  - 4 ISTAT (W1C)
  - 5 IRISE (RW; rising-edge enable)
  - 6 IFALL (RW; falling-edge enable)
  - 7 reserved, or TOGGLE (see Configuration)
- Write: occurs on any cycle with r_wn=0; only the bytes whose wben bit is 1 are updated. wben=0 is a no-op.
- Bits at or above GPIO_W: ignored on write, read as 0. Writes to RO or reserved addresses are ignored.
- Read: on any cycle with r_wn=1, rdata loads the addressed register on the next edge. Reads have no side effects. rdata holds its value while r_wn=0.
- Edge detect: per bit, compare the synchroniser output with its one-cycle-delayed copy.
  - A rise with IRISE=1, or a fall with IFALL=1, sets the ISTAT bit.
- Edges are detected regardless of IMASK; IMASK gates only irq.
- Same-cycle ISTAT set and W1C clear on the same bit: the set wins and the bit stays 1.
- irq updates every cycle to |(ISTAT & IMASK).
- Reset values:
  - DATA, TRISTATE, IMASK, IRISE, IFALL, ISTAT, rdata, irq: 0.
  - Synchronisers and the delayed copy: 0.
  - A pin held high through reset therefore reports a rise after release if IRISE=1. This is required behaviour.

## Timing
- Write: registers and rf_* outputs update on the edge that samples the write, i.e. 1 cycle.
- Read latency: 1 cycle from addr/r_wn to rdata.
- Pin change to PINSTATE readable: SYNC_STAGES edges.
- Pin change to ISTAT set: SYNC_STAGES+1 edges.
- Pin change to irq: SYNC_STAGES+2 edges.
- Clearing ISTAT via W1C: irq deasserts 1 cycle after the ISTAT update.
- Writing IMASK=0: irq deasserts 1 cycle after the IMASK update.
- Pulses shorter than one clk period may be missed. No pulse-stretching is provided.
- Asserting reset mid-access aborts the access. All state clears immediately, without waiting for clk.

## Configuration
- GPIO_TOGGLE_EN defined: addr 7 is TOGGLE, write-only.
  - Each written 1 inverts the corresponding DATA bit; byte enables apply. Reads return 0.
  - A TOGGLE write and a DATA write cannot collide, because there is one address per cycle.
- GPIO_TOGGLE_EN undefined: addr 7 is reserved. Writes are ignored and reads return 0. No toggle logic is synthesised.

## Structure
- Package gpio_pkg holds:
  - the address constants (GPIO_ADDR_DATA … GPIO_ADDR_TOGGLE);
  - the max-width constant 32;
  - the register-index enumeration typedef.
- Sub-module gpio_sync (parameters W and STAGES):
  - contains the synchroniser chain and the delayed copy;
  - outputs sync_q, rise and fall vectors;
  - is instantiated once for all GPIO_W bits.

## Test plan
- Reset, then read all 8 addresses → all return 0; irq=0; all rf_* outputs are 0.
- Write DATA=0x1234_ABCD with wben=4'b0010, GPIO_W=16 → DATA reads 0x0000_AB00; bits 31:16 always read 0.
- IRISE=0x0001, IMASK=0x0001, then drive pin0 0→1 → ISTAT=0x0001 after 3 edges and irq=1 after 4 (SYNC_STAGES=2). Write ISTAT=0x0001 → irq=0 one cycle later.
- IFALL=0x8000, IMASK=0: pin15 1→0 → ISTAT bit15 sets but irq stays 0. Then write IMASK=0x8000 → irq=1 next cycle.
- W1C of ISTAT bit0 on the same edge as a new detected rise on pin0 → ISTAT bit0 remains 1.
- With GPIO_TOGGLE_EN: DATA=0x00FF, write TOGGLE=0x0F0F → DATA=0x0FF0 and TOGGLE reads 0. Without the macro, the same write leaves DATA at 0x00FF.
